// File: rtl/basic_vector_checker_if.sv
// rtl/basic_vector_checker_if.sv - Control, status and DUT-facing signals of the vector checker
//
// Purpose: bundles the signals exchanged between basic_vector_checker and its
// surroundings: the start/status signals toward the host and a/b/c/f1 toward
// the combinational block under test.
//
// Signals:
//   start           host -> checker   single-cycle pulse that begins a run
//   a, b, c         checker -> DUT    drive inputs (vector bits 2, 1, 0)
//   f1              DUT -> checker    output of the block under test
//   busy, done      checker -> host   run in progress / run finished
//   pass            checker -> host   done with zero mismatches
//   err_count       checker -> host   saturating mismatch count
//   first_fail_idx  checker -> host   vector index of the first mismatch
//   first_fail_vld  checker -> host   first_fail_idx holds a real index
//
// Modports: master = checker side, slave = host/DUT side.
interface basic_vector_checker_if #(
  parameter int N_IN  = 3,
  parameter int CNT_W = 4
);
  logic             start;
  logic             a;
  logic             b;
  logic             c;
  logic             f1;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [N_IN-1:0]  first_fail_idx;
  logic             first_fail_vld;

  modport master (
    input  start, f1,
    output a, b, c, busy, done, pass, err_count, first_fail_idx, first_fail_vld
  );

  modport slave (
    output start, f1,
    input  a, b, c, busy, done, pass, err_count, first_fail_idx, first_fail_vld
  );
endinterface

// File: rtl/basic_vector_checker.sv
// rtl/basic_vector_checker.sv - Built-in exhaustive vector checker for the 3-input block basic
//
// Purpose: on a start pulse, steps every input combination onto a/b/c, holds
// each for a settle period, samples f1 and compares it with EXP_TABLE. Reports
// a saturating mismatch count, the first failing index and a pass flag.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   bus   master modport of basic_vector_checker_if (start, a/b/c, f1, status)
module basic_vector_checker #(
  parameter int                   N_IN      = 3,
  parameter logic [(1<<N_IN)-1:0] EXP_TABLE = 8'hE8,
  parameter int                   SETTLE    = 2,
  parameter int                   CNT_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  basic_vector_checker_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

  logic [1:0]       state;
  logic [N_IN-1:0]  vec;
  logic [CW-1:0]    cnt;
  logic [CNT_W-1:0] err;
  logic [N_IN-1:0]  ff_idx;
  logic             ff_vld;
  logic             start_q;
  logic             mismatch;

  assign mismatch = (bus.f1 != EXP_TABLE[vec]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      vec     <= '0;
      cnt     <= '0;
      err     <= '0;
      ff_idx  <= '0;
      ff_vld  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      // start is registered once and only captured while not running, so a
      // pulse during a run never leaks into the following DONE state.
      start_q <= bus.start && ((state == S_IDLE) || (state == S_DONE));
      case (state)
        S_IDLE, S_DONE: begin
          if (start_q) begin
            state  <= S_SETTLE;
            vec    <= '0;
            cnt    <= '0;
            err    <= '0;
            ff_idx <= '0;
            ff_vld <= 1'b0;
          end
        end
        S_SETTLE: begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (mismatch) begin
            if (err != ERR_MAX) begin
              err <= err + CNT_W'(1);
            end
            if (!ff_vld) begin
              ff_idx <= vec;
              ff_vld <= 1'b1;
            end
          end
          if (vec == VEC_LAST) begin
            state <= S_DONE;
          end else begin
            vec   <= vec + N_IN'(1);
            cnt   <= '0;
            state <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // a/b/c come straight from the vec register, so they are glitch-free and
  // hold the last vector in DONE.
  assign bus.a              = vec[2];
  assign bus.b              = vec[1];
  assign bus.c              = vec[0];
  assign bus.busy           = (state == S_SETTLE) || (state == S_SAMPLE);
  assign bus.done           = (state == S_DONE);
  assign bus.pass           = (state == S_DONE) && (err == '0);
  assign bus.err_count      = err;
  assign bus.first_fail_idx = ff_idx;
  assign bus.first_fail_vld = ff_vld;

endmodule

// File: tb/tb_basic_vector_checker.sv
// tb/tb_basic_vector_checker.sv - Self-checking bench for basic_vector_checker
module tb_basic_vector_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] f1_tab0 = 8'h00;
  logic [2:0] abc_log [0:79];

  basic_vector_checker_if #(.N_IN(3), .CNT_W(4)) bus0 ();
  basic_vector_checker_if #(.N_IN(3), .CNT_W(2)) bus1 ();

  assign bus0.f1 = f1_tab0[{bus0.a, bus0.b, bus0.c}];
  assign bus1.f1 = 1'b1;

  basic_vector_checker #(.N_IN(3), .EXP_TABLE(8'hE8), .SETTLE(2), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  basic_vector_checker #(.N_IN(3), .EXP_TABLE(8'h00), .SETTLE(2), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  function automatic logic [7:0] majority_tab();
    logic [7:0] t;
    for (int k = 0; k < 8; k++) t[k] = (((k >> 2) & 1) + ((k >> 1) & 1) + (k & 1)) >= 2;
    return t;
  endfunction

  // Expected results of a full run: f1 table vs expected table, saturating count.
  function automatic void model(input logic [7:0] tab, input logic [7:0] expt, input int cw,
                                output int err, output int ffi, output int ffv);
    err = 0; ffi = 0; ffv = 0;
    for (int k = 0; k < 8; k++) begin
      if (tab[k] != expt[k]) begin
        if (err < (1 << cw) - 1) err++;
        if (ffv == 0) begin ffi = k; ffv = 1; end
      end
    end
  endfunction

  // Pulses start (sampled at edge 0), optionally pulses again at edges p1/p2,
  // logs a/b/c after every edge and returns the edge at which done rose.
  task automatic run0(input int p1, input int p2, output int done_edge);
    bit seen_busy;
    seen_busy = 0;
    done_edge = -1;
    @(negedge clk);
    bus0.start = 1'b1;
    for (int e = 0; e < 80; e++) begin
      @(negedge clk);
      abc_log[e] = {bus0.a, bus0.b, bus0.c};
      if (bus0.busy) seen_busy = 1;
      bus0.start = (e + 1 == p1) || (e + 1 == p2);
      if (seen_busy && bus0.done) begin
        done_edge = e;
        break;
      end
    end
    bus0.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({bus0.a, bus0.b, bus0.c} !== 3'b000) begin errors++; $display("FAIL reset_abc: got %b expected 000", {bus0.a, bus0.b, bus0.c}); end
    checks++; if ({bus0.busy, bus0.done, bus0.pass} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus0.busy, bus0.done, bus0.pass}); end
    checks++; if (bus0.err_count !== 4'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", bus0.err_count); end
    checks++; if ({bus0.first_fail_idx, bus0.first_fail_vld} !== 4'b0000) begin errors++; $display("FAIL reset_first_fail: got %b expected 0000", {bus0.first_fail_idx, bus0.first_fail_vld}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_majority(input int p1, input int p2, input string tag);
    int de, m_err, m_ffi, m_ffv;
    f1_tab0 = majority_tab();
    model(f1_tab0, 8'hE8, 4, m_err, m_ffi, m_ffv);
    run0(p1, p2, de);
    checks++; if (de !== 25) begin errors++; $display("FAIL %s_done_edge: got %0d expected 25", tag, de); end
    for (int e = 1; e < 25 && e <= de; e++) begin
      checks++;
      if (abc_log[e] !== 3'((e - 1) / 3)) begin errors++; $display("FAIL %s_abc_edge%0d: got %0d expected %0d", tag, e, abc_log[e], (e - 1) / 3); end
    end
    checks++; if (bus0.pass !== 1'b1) begin errors++; $display("FAIL %s_pass: got %b expected 1", tag, bus0.pass); end
    checks++; if (int'(bus0.err_count) !== m_err) begin errors++; $display("FAIL %s_err: got %0d expected %0d", tag, bus0.err_count, m_err); end
    checks++; if (int'(bus0.first_fail_vld) !== m_ffv) begin errors++; $display("FAIL %s_ffv: got %b expected %0d", tag, bus0.first_fail_vld, m_ffv); end
    checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done: got %b expected 0", tag, bus0.busy); end
    repeat (3) @(negedge clk);
    checks++; if ({bus0.a, bus0.b, bus0.c, bus0.done} !== 4'b1111) begin errors++; $display("FAIL %s_hold: got %b expected 1111", tag, {bus0.a, bus0.b, bus0.c, bus0.done}); end
  endtask

  task automatic test_tied_zero();
    int de, m_err, m_ffi, m_ffv;
    f1_tab0 = 8'h00;
    model(f1_tab0, 8'hE8, 4, m_err, m_ffi, m_ffv);
    run0(-1, -1, de);
    checks++; if (de !== 25) begin errors++; $display("FAIL tie0_done_edge: got %0d expected 25", de); end
    checks++; if (int'(bus0.err_count) !== m_err) begin errors++; $display("FAIL tie0_err: got %0d expected %0d", bus0.err_count, m_err); end
    checks++; if (int'(bus0.first_fail_idx) !== m_ffi) begin errors++; $display("FAIL tie0_ffi: got %0d expected %0d", bus0.first_fail_idx, m_ffi); end
    checks++; if (int'(bus0.first_fail_vld) !== m_ffv) begin errors++; $display("FAIL tie0_ffv: got %b expected %0d", bus0.first_fail_vld, m_ffv); end
    checks++; if (bus0.pass !== 1'b0) begin errors++; $display("FAIL tie0_pass: got %b expected 0", bus0.pass); end
  endtask

  task automatic test_saturate();
    int de, m_err, m_ffi, m_ffv;
    bit seen_busy;
    model(8'hFF, 8'h00, 2, m_err, m_ffi, m_ffv);
    de = -1; seen_busy = 0;
    @(negedge clk);
    bus1.start = 1'b1;
    for (int e = 0; e < 80; e++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      if (bus1.busy) seen_busy = 1;
      if (seen_busy && bus1.done) begin de = e; break; end
    end
    checks++; if (de !== 25) begin errors++; $display("FAIL sat_done_edge: got %0d expected 25", de); end
    checks++; if (int'(bus1.err_count) !== m_err) begin errors++; $display("FAIL sat_err: got %0d expected %0d", bus1.err_count, m_err); end
    checks++; if (int'(bus1.first_fail_idx) !== m_ffi) begin errors++; $display("FAIL sat_ffi: got %0d expected %0d", bus1.first_fail_idx, m_ffi); end
    checks++; if (bus1.pass !== 1'b0) begin errors++; $display("FAIL sat_pass: got %b expected 0", bus1.pass); end
  endtask

  task automatic test_mid_reset();
    int pre_err;
    f1_tab0 = 8'hFF;
    pre_err = 0;
    for (int k = 0; k < 3; k++) if (f1_tab0[k] != 8'hE8 >> k & 8'h01) pre_err++;
    @(negedge clk);
    bus0.start = 1'b1;
    @(posedge clk);
    #1 bus0.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (int'(bus0.err_count) !== pre_err) begin errors++; $display("FAIL midrst_pre_err: got %0d expected %0d", bus0.err_count, pre_err); end
    checks++; if ({bus0.a, bus0.b, bus0.c} !== 3'd3) begin errors++; $display("FAIL midrst_pre_abc: got %b expected 011", {bus0.a, bus0.b, bus0.c}); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({bus0.a, bus0.b, bus0.c} !== 3'b000) begin errors++; $display("FAIL midrst_abc: got %b expected 000", {bus0.a, bus0.b, bus0.c}); end
    checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus0.busy); end
    checks++; if (bus0.err_count !== 4'd0) begin errors++; $display("FAIL midrst_err: got %0d expected 0", bus0.err_count); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if ({bus0.busy, bus0.done, bus0.first_fail_vld} !== 3'b000) begin errors++; $display("FAIL midrst_idle: got %b expected 000", {bus0.busy, bus0.done, bus0.first_fail_vld}); end
  endtask

  task automatic test_back_to_back();
    int de;
    bit seen_busy;
    test_tied_zero();
    f1_tab0 = majority_tab();
    @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    @(negedge clk);
    checks++; if ({bus0.busy, bus0.pass, bus0.first_fail_vld} !== 3'b100) begin errors++; $display("FAIL b2b_restart_flags: got %b expected 100", {bus0.busy, bus0.pass, bus0.first_fail_vld}); end
    checks++; if (bus0.err_count !== 4'd0) begin errors++; $display("FAIL b2b_restart_err: got %0d expected 0", bus0.err_count); end
    de = -1; seen_busy = 1;
    for (int e = 2; e < 80; e++) begin
      @(negedge clk);
      if (seen_busy && bus0.done) begin de = e; break; end
    end
    checks++; if (de !== 25) begin errors++; $display("FAIL b2b_done_edge: got %0d expected 25", de); end
    checks++; if ({bus0.pass, bus0.err_count} !== 5'b10000) begin errors++; $display("FAIL b2b_result: got pass=%b err=%0d expected pass=1 err=0", bus0.pass, bus0.err_count); end
  endtask

  task automatic test_random();
    int de, m_err, m_ffi, m_ffv;
    for (int it = 0; it < 6; it++) begin
      f1_tab0 = 8'($urandom);
      model(f1_tab0, 8'hE8, 4, m_err, m_ffi, m_ffv);
      run0(-1, -1, de);
      checks++; if (de !== 25) begin errors++; $display("FAIL rnd%0d_done_edge: got %0d expected 25", it, de); end
      checks++; if (int'(bus0.err_count) !== m_err) begin errors++; $display("FAIL rnd%0d_err: tab=%h got %0d expected %0d", it, f1_tab0, bus0.err_count, m_err); end
      checks++; if (int'(bus0.first_fail_vld) !== m_ffv) begin errors++; $display("FAIL rnd%0d_ffv: tab=%h got %b expected %0d", it, f1_tab0, bus0.first_fail_vld, m_ffv); end
      if (m_ffv == 1) begin
        checks++; if (int'(bus0.first_fail_idx) !== m_ffi) begin errors++; $display("FAIL rnd%0d_ffi: tab=%h got %0d expected %0d", it, f1_tab0, bus0.first_fail_idx, m_ffi); end
      end
      checks++; if (int'(bus0.pass) !== int'(m_err == 0)) begin errors++; $display("FAIL rnd%0d_pass: tab=%h got %b expected %0d", it, f1_tab0, bus0.pass, m_err == 0); end
    end
  endtask

  initial begin
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    test_reset();
    test_majority(-1, -1, "maj");
    test_tied_zero();
    test_saturate();
    test_majority(5, 12, "extra_start");
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
